// File: rtl/int_mul_add_seq_pkg.sv
// rtl/int_mul_add_seq_pkg.sv - shared integer-unit constants, state encoding and lane slicing
package int_mul_add_seq_pkg;

    // Default lane width and lane count shared with the vector divider
    localparam int DEF_N = 32;
    localparam int DEF_L = 4;

    // Sequencer states for one vector operation in flight
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Lane i of a lane-packed bus starts at bit i*n and is n bits wide
    function automatic int lane_lo(input int i, input int n);
        return i * n;
    endfunction

endpackage

// File: rtl/int_mul_add_lane.sv
// rtl/int_mul_add_lane.sv - one lane of the radix-2 shift-add q*d+r datapath
module int_mul_add_lane
    import int_mul_add_seq_pkg::*;
#(
    parameter int N = DEF_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         load,
    input  logic         step,
    input  logic         last,
    input  logic [N-1:0] q_in,
    input  logic [N-1:0] d_in,
    input  logic [N-1:0] r_in,
    output logic [N-1:0] numer_out,
    output logic         ovf_out
);

    // The accumulator is one bit wider than 2N so the full product-plus-addend never wraps
    logic [N-1:0]   mreg_q, mreg_d;
    logic [2*N-1:0] dreg_q, dreg_d;
    logic [2*N:0]   acc_q, acc_d;
    logic [N-1:0]   numer_q, numer_d;
    logic           ovf_q, ovf_d;

    // Load operands, then one shift-add step per RUN cycle; results latch on the final step
    always_comb begin
        mreg_d  = mreg_q;
        dreg_d  = dreg_q;
        acc_d   = acc_q;
        numer_d = numer_q;
        ovf_d   = ovf_q;
        if (load) begin
            mreg_d = q_in;
            dreg_d = {{N{1'b0}}, d_in};
            acc_d  = {{(N+1){1'b0}}, r_in};
        end else if (step) begin
            if (mreg_q[0]) begin
                acc_d = acc_q + {1'b0, dreg_q};
            end
            mreg_d = mreg_q >> 1;
            dreg_d = dreg_q << 1;
            if (last) begin
                numer_d = acc_d[N-1:0];
                ovf_d   = |acc_d[2*N:N];
            end
        end
    end

    // Lane registers: reset clears everything, clk_en low freezes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            mreg_q  <= '0;
            dreg_q  <= '0;
            acc_q   <= '0;
            numer_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clk_en) begin
            mreg_q  <= mreg_d;
            dreg_q  <= dreg_d;
            acc_q   <= acc_d;
            numer_q <= numer_d;
            ovf_q   <= ovf_d;
        end
    end

    assign numer_out = numer_q;
    assign ovf_out   = ovf_q;

endmodule

// File: rtl/int_mul_add_seq.sv
// rtl/int_mul_add_seq.sv - L-lane sequential numer = quotient*denom + remainder
module int_mul_add_seq
    import int_mul_add_seq_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int L = DEF_L
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N*L-1:0] quotient,
    input  logic [N*L-1:0] denom,
    input  logic [N*L-1:0] remainder,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N*L-1:0] numer,
    output logic [L-1:0] ovf,
    output logic         busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            load, step, last;

    // Lane controls; the lanes themselves apply clk_en
    assign load = (state_q == ST_IDLE) && in_valid;
    assign step = (state_q == ST_RUN);
    assign last = (cnt_q == CW'(N - 1));

    // Next state: fixed N RUN cycles regardless of data, registered handshake outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (last) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Sequencer registers: reset aborts any operation, clk_en low holds state and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (clk_en) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    for (genvar i = 0; i < L; i++) begin : g_lane
        int_mul_add_lane #(.N(N)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .clk_en    (clk_en),
            .load      (load),
            .step      (step),
            .last      (last),
            .q_in      (quotient[lane_lo(i, N) +: N]),
            .d_in      (denom[lane_lo(i, N) +: N]),
            .r_in      (remainder[lane_lo(i, N) +: N]),
            .numer_out (numer[lane_lo(i, N) +: N]),
            .ovf_out   (ovf[i])
        );
    end

endmodule

// File: tb/tb_int_mul_add_seq.sv
// tb/tb_int_mul_add_seq.sv - self-checking bench for int_mul_add_seq
module tb_int_mul_add_seq;

    localparam int N = 32;
    localparam int L = 4;
    localparam int W = N * L;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] denom;
    logic [W-1:0] remainder;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] numer;
    logic [L-1:0] ovf;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    int_mul_add_seq #(.N(N), .L(L)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quotient  (quotient),
        .denom     (denom),
        .remainder (remainder),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .numer     (numer),
        .ovf       (ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] d;
        logic [W-1:0] r;
        logic [W-1:0] exp_numer;
        logic [L-1:0] exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact unsigned q*d+r per lane in wide arithmetic
    function automatic void model(input logic [W-1:0] q, input logic [W-1:0] d,
                                  input logic [W-1:0] r,
                                  output logic [W-1:0] n, output logic [L-1:0] o);
        logic [2*N+1:0] full;
        n = '0;
        o = '0;
        for (int i = 0; i < L; i++) begin
            full = (2*N+2)'(q[i*N +: N]) * (2*N+2)'(d[i*N +: N]) + (2*N+2)'(r[i*N +: N]);
            n[i*N +: N] = full[N-1:0];
            o[i] = (full >> N) != 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, then present operands for exactly one accepting edge
    task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r);
        int n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        quotient  = q;
        denom     = d;
        remainder = r;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    // Count edges until out_valid is seen
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r,
                          output logic [W-1:0] n, output logic [L-1:0] o, output int lat);
        send(q, d, r);
        wait_valid(lat);
        n = numer;
        o = ovf;
        accept_out();
    endtask

    vec_t         tbl[4];
    logic [W-1:0] rn, rq, rd, rr, en, hold_n;
    logic [L-1:0] ro, eo;
    int           lat;
    int           bad;
    logic [N-1:0] a, b;

    initial begin
        rst       = 1'b1;
        clk_en    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        quotient  = '0;
        denom     = '0;
        remainder = '0;
        tick();
        tick();

        // Reset state
        chk("rst_in_ready", W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_numer", numer, '0);
        chk("rst_ovf", W'(ovf), W'(0));

        // rst wins over a transfer on the same edge
        in_valid = 1'b1;
        quotient = {4{32'd3}};
        denom    = {4{32'd3}};
        tick();
        in_valid = 1'b0;
        chk("rst_vs_xfer_in_ready", W'(in_ready), W'(1));
        chk("rst_vs_xfer_busy", W'(busy), W'(0));
        rst = 1'b0;
        tick();

        // Directed vectors
        tbl[0] = '{q: {32'd12345, 32'd1, 32'd0, 32'd7},
                   d: {32'd678, 32'd0, 32'd5, 32'd3},
                   r: {32'd100, 32'd4, 32'd9, 32'd2},
                   exp_numer: {32'd8370010, 32'd4, 32'd9, 32'd23},
                   exp_ovf: 4'b0000};
        tbl[1] = '{q: {32'd2, 32'h00010000, 32'h00010000, 32'hFFFFFFFF},
                   d: {32'h80000000, 32'h0000FFFF, 32'h00010000, 32'hFFFFFFFF},
                   r: {32'd5, 32'h0000FFFF, 32'd0, 32'hFFFFFFFF},
                   exp_numer: {32'd5, 32'hFFFFFFFF, 32'd0, 32'd0},
                   exp_ovf: 4'b1011};
        tbl[2] = '{q: '0, d: '0, r: '0, exp_numer: '0, exp_ovf: 4'b0000};
        tbl[3] = '{q: {4{32'd1}}, d: {4{32'hFFFFFFFF}}, r: {4{32'd1}},
                   exp_numer: '0, exp_ovf: 4'b1111};
        for (int i = 0; i < 4; i++) begin
            run_op(tbl[i].q, tbl[i].d, tbl[i].r, rn, ro, lat);
            chk($sformatf("tbl%0d_numer", i), rn, tbl[i].exp_numer);
            chk($sformatf("tbl%0d_ovf", i), W'(ro), W'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_latency", i), W'(lat), W'(N));
        end

        // Backpressure: hold out_ready low in DONE while a second vector waits
        send(tbl[0].q, tbl[0].d, tbl[0].r);
        wait_valid(lat);
        chk("bp_latency", W'(lat), W'(N));
        quotient  = tbl[1].q;
        denom     = tbl[1].d;
        remainder = tbl[1].r;
        in_valid  = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!out_valid || !busy || in_ready || numer !== tbl[0].exp_numer || ovf !== tbl[0].exp_ovf)
                bad++;
        end
        chk("bp_stable_cycles_bad", W'(bad), W'(0));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_out_valid", W'(out_valid), W'(0));
        chk("bp_release_in_ready", W'(in_ready), W'(1));
        chk("bp_release_numer_held", numer, tbl[0].exp_numer);
        tick();
        in_valid = 1'b0;
        chk("bp_second_accepted", W'(in_ready), W'(0));
        wait_valid(lat);
        chk("bp_second_latency", W'(lat), W'(N));
        chk("bp_second_numer", numer, tbl[1].exp_numer);
        chk("bp_second_ovf", W'(ovf), W'(tbl[1].exp_ovf));
        accept_out();

        // clk_en gating mid-RUN
        send(tbl[0].q, tbl[0].d, tbl[0].r);
        repeat (10) tick();
        clk_en = 1'b0;
        repeat (5) tick();
        chk("gate_busy_held", W'(busy), W'(1));
        clk_en = 1'b1;
        wait_valid(lat);
        chk("gate_latency", W'(lat + 15), W'(N + 5));
        chk("gate_numer", numer, tbl[0].exp_numer);
        chk("gate_ovf", W'(ovf), W'(tbl[0].exp_ovf));
        accept_out();

        // Reset mid-operation at cnt=10
        send(tbl[1].q, tbl[1].d, tbl[1].r);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out_valid", W'(out_valid), W'(0));
        chk("abort_in_ready", W'(in_ready), W'(1));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_numer", numer, '0);
        chk("abort_ovf", W'(ovf), W'(0));
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || !in_ready) bad++;
        end
        chk("abort_no_result", W'(bad), W'(0));

        // Random operands against the reference model
        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < L; i++) begin
                rq[i*N +: N] = $urandom >> $urandom_range(0, 31);
                rd[i*N +: N] = $urandom >> $urandom_range(0, 31);
                rr[i*N +: N] = $urandom;
            end
            model(rq, rd, rr, en, eo);
            run_op(rq, rd, rr, rn, ro, lat);
            chk($sformatf("rand%0d_numer", k), rn, en);
            chk($sformatf("rand%0d_ovf", k), W'(ro), W'(eo));
            chk($sformatf("rand%0d_latency", k), W'(lat), W'(N));
        end

        // Round trip through division: q*d+r must rebuild the original numerator
        for (int k = 0; k < 1000; k++) begin
            for (int i = 0; i < L; i++) begin
                a = $urandom;
                b = $urandom >> $urandom_range(0, 31);
                if (b == 0) b = 1;
                hold_n[i*N +: N] = a;
                rd[i*N +: N] = b;
                rq[i*N +: N] = a / b;
                rr[i*N +: N] = a % b;
            end
            run_op(rq, rd, rr, rn, ro, lat);
            chk($sformatf("rt%0d_numer", k), rn, hold_n);
            chk($sformatf("rt%0d_ovf", k), W'(ro), W'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_mul_add_seq.md
Name: int_mul_add_seq

Overview:
- Inverse-direction companion to the vector integer divider in the fpunit.
- For each of L lanes it reconstructs numer = quotient*denom + remainder, using a radix-2 shift-add datapath over N iterations.
- Used to check divider results and to rebuild operands in the integer pipeline.
- Valid/ready handshake on input and output; one vector operation in flight.

Parameters:
- N, 32, lane width in bits (unsigned).
- L, 4, number of lanes, processed in parallel.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset; overrides clk_en.
- clk_en  input  1  global enable; when 0, all state and outputs hold.
- in_valid  input  1  operand vector valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- quotient  input  N*L  lane i at bits [(i+1)*N-1 : i*N]; multiplier.
- denom  input  N*L  lane-packed; multiplicand.
- remainder  input  N*L  lane-packed; addend.
- out_valid  output  1  result vector valid.
- out_ready  input  1  consumer accepts result.
- numer  output  N*L  lane-packed result, low N bits of q*d+r.
- ovf  output  L  per lane: 1 when the true q*d+r is at least 2^N.
- busy  output  1  high in RUN and DONE.

Behaviour:
- All arithmetic is unsigned. Each lane uses an accumulator of 2N+1 bits, so the full result can never wrap.
- Reset: state goes to IDLE, counter to 0, and all lane registers are cleared. Outputs after reset: in_ready=1, out_valid=0, busy=0, numer=0, ovf=0.
- clk_en=0: nothing changes, including the handshake. A transfer happens only on an edge where clk_en=1.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture per lane: mreg=quotient (N bits), dreg=denom zero-extended to 2N bits, acc=remainder zero-extended.
  - Set cnt=0 and go to RUN.
- RUN (exactly N cycles, cnt 0..N-1), every lane each cycle:
  - If mreg[0], add dreg to acc.
  - Then shift mreg right by 1 and dreg left by 1.
  - When cnt==N-1, go to DONE; otherwise increment cnt.
- DONE:
  - On entry: numer lane = acc[N-1:0], and ovf[i] = OR of acc[2N:N] (the upper bits).
  - out_valid=1. numer and ovf stay stable while out_valid=1 and out_ready=0.
  - On out_ready, go to IDLE: out_valid drops next cycle and in_ready rises the same cycle.
  - numer and ovf keep their last values after the handoff.
- Latency: input accepted at edge t gives out_valid=1 after edge t+N. Throughput is one vector per N+2 cycles at best.
- Early exit is not allowed. The cycle count is fixed at N whatever the data, even when quotient=0.
- Zero denominator needs no special case: the result is the remainder and ovf=0. This matches the divider's disabled zero-denominator lanes.
- in_valid seen outside IDLE is ignored, since in_ready=0. The source must hold its operands until the transfer.
- Reset in RUN or DONE aborts the operation. The partial result is discarded, out_valid=0 next cycle, and no result is produced.
- rst and a transfer on the same edge: rst wins.

Decomposition:
- Shared package (fpunit int pkg):
  - State encoding IDLE, RUN, DONE.
  - Default N and L, used as constants by both the divider and this block.
  - A lane-slice helper constant: lane i spans width N at offset i*N.
- One sub-module: int_mul_add_lane (N-bit shift-add slice holding mreg, dreg and acc). It takes load/step controls from the shared FSM and counter in the top module, and is instantiated L times with generate.
- The top module owns the FSM, the counter and the handshake.

Test Plan:
- Basic: N=32, L=4. Lanes q/d/r = 7/3/2, 0/5/9, 1/0/4, 12345/678/100 -> numer 23, 9, 4, 8370010; ovf=0000. out_valid rises 32 cycles after the accept edge.
- Overflow: lane0 q=0xFFFFFFFF, d=0xFFFFFFFF, r=0xFFFFFFFF -> numer lane0=0x00000000, ovf[0]=1. lane1 q=0x10000, d=0x10000, r=0 -> numer 0, ovf[1]=1. lane2 q=0x10000, d=0xFFFF, r=0xFFFF -> numer 0xFFFFFFFF, ovf[2]=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and numer stable, in_ready=0, and a second in_valid is ignored. Release -> in_ready=1 on the next cycle, then the second vector is accepted and correct.
- clk_en gating: drop clk_en for 5 cycles mid-RUN -> completion is delayed by exactly 5 cycles and the results are unchanged.
- Reset mid-operation: assert rst at cnt=10 -> next cycle state is IDLE, out_valid=0, numer=0, ovf=0, in_ready=1. The result of the aborted operation never appears.
- Round trip with the divider: random numer/denom (denom≠0) through the divider, then this block -> numer reproduced bit-exact with ovf=0 on all lanes, over 1000 vectors.
